serialiser_tx_sched: RTL and testbench

- Transmit symbol scheduler in front of the per-lane 8b10b encoders that feed the Serialiser.
- Each symbol-clock cycle, it picks which 9-bit symbol ({K, byte}) every lane carries. Sources, highest priority first: periodic SKP ordered sets, training ordered sets, data packets.
- It guarantees packet atomicity and SKP insertion on schedule.
- When nothing is granted, it emits logical idle.

---
 rtl/serialiser_tx_sched_pkg.sv | 17 +
 rtl/serialiser_skp_timer.sv | 35 +++
 rtl/serialiser_tx_sched.sv | 124 ++++++++++++
 tb/tb_serialiser_tx_sched.sv | 190 +++++++++++++++++++
 4 files changed

// File: rtl/serialiser_tx_sched_pkg.sv
// Shared symbol constants and scheduler state encoding for the serialiser
// transmit path.
package serialiser_tx_sched_pkg;

   localparam logic [8:0] COM_SYM = 9'h1BC;
   localparam logic [8:0] SKP_SYM = 9'h11C;
   localparam logic [8:0] IDL_SYM = 9'h000;

   typedef enum logic [2:0] {
      TXS_IDLE     = 3'd0,
      TXS_SKP_COM  = 3'd1,
      TXS_SKP_BODY = 3'd2,
      TXS_OS       = 3'd3,
      TXS_DATA     = 3'd4
   } txs_state_t;

endpackage

// File: rtl/serialiser_skp_timer.sv
// Saturating SKP interval counter: raises SkpPending once per interval and
// holds it until the scheduler starts the SKP ordered set.
module serialiser_skp_timer
#(
   parameter int SkpInterval = 1180
) (
   input  logic Clk,
   input  logic notReset,
   input  logic SkpEnable,
   input  logic SkpStart,
   output logic SkpPending
);

   localparam int CntW = $clog2(SkpInterval);
   localparam logic [CntW-1:0] CNT_LAST = CntW'(SkpInterval - 1);
   localparam logic [CntW-1:0] CNT_PRE  = CntW'(SkpInterval - 2);

   logic [CntW-1:0] skp_cnt_reg;
   logic            skp_pending_reg;

   // Pending rises together with the count reaching its last value, so a
   // grant in the following cycle keeps COM starts exactly SkpInterval apart.
   always_ff @(posedge Clk) begin
      if (!notReset || !SkpEnable || SkpStart) begin
         skp_cnt_reg     <= '0;
         skp_pending_reg <= 1'b0;
      end else if (skp_cnt_reg != CNT_LAST) begin
         skp_cnt_reg     <= skp_cnt_reg + CntW'(1);
         skp_pending_reg <= (skp_cnt_reg == CNT_PRE);
      end
   end

   assign SkpPending = skp_pending_reg;

endmodule

// File: rtl/serialiser_tx_sched.sv
// Per-cycle symbol scheduler for all lanes: SKP ordered sets beat training
// ordered sets, which beat data packets; grants are taken only in IDLE.
module serialiser_tx_sched
   import serialiser_tx_sched_pkg::*;
#(
   parameter int Width       = 16,
   parameter int SkpInterval = 1180,
   parameter int SkpLen      = 3
) (
   input  logic               Clk,
   input  logic               notReset,
   input  logic               SkpEnable,
   input  logic               OsValid,
   input  logic [8:0]         OsSym,
   input  logic               OsLast,
   output logic               OsReady,
   input  logic               DataValid,
   input  logic [Width*9-1:0] DataVec,
   input  logic               DataLast,
   output logic               DataReady,
   output logic [Width*9-1:0] TxSymVec,
   output logic               SkpActive,
   output logic               Underrun
);

   localparam logic [2:0] IDX_LAST = 3'(SkpLen - 1);

   txs_state_t         state_reg;
   logic [2:0]         skp_idx_reg;
   logic [Width*9-1:0] tx_sym_vec_reg;
   logic               skp_active_reg;
   logic               underrun_reg;
   logic [Width*9-1:0] os_bcast;
   logic               skp_pending;
   logic               skp_start;
   logic               idle_free;

   generate
      for (genvar gi = 0; gi < Width; gi++) begin : g_lane
         assign os_bcast[gi*9 +: 9] = OsSym;
      end
   endgenerate

   serialiser_skp_timer #(
      .SkpInterval(SkpInterval)
   ) u_skp_timer (
      .Clk       (Clk),
      .notReset  (notReset),
      .SkpEnable (SkpEnable),
      .SkpStart  (skp_start),
      .SkpPending(skp_pending)
   );

   assign idle_free = (state_reg == TXS_IDLE) && !skp_pending;
   assign skp_start = (state_reg == TXS_IDLE) && skp_pending;
   // No transfers are offered while reset is held.
   assign OsReady   = notReset && OsValid && (idle_free || state_reg == TXS_OS);
   assign DataReady = notReset && ((idle_free && !OsValid && DataValid) ||
                                   state_reg == TXS_DATA);

   always_ff @(posedge Clk) begin
      if (!notReset) begin
         state_reg      <= TXS_IDLE;
         skp_idx_reg    <= '0;
         tx_sym_vec_reg <= {Width{IDL_SYM}};
         skp_active_reg <= 1'b0;
         underrun_reg   <= 1'b0;
      end else begin
         tx_sym_vec_reg <= {Width{IDL_SYM}};
         skp_active_reg <= 1'b0;
         underrun_reg   <= 1'b0;
         case (state_reg)
            TXS_IDLE: begin
               if (skp_pending) begin
                  state_reg      <= TXS_SKP_COM;
                  tx_sym_vec_reg <= {Width{COM_SYM}};
                  skp_active_reg <= 1'b1;
               end else if (OsValid) begin
                  tx_sym_vec_reg <= os_bcast;
                  if (!OsLast) state_reg <= TXS_OS;
               end else if (DataValid) begin
                  tx_sym_vec_reg <= DataVec;
                  if (!DataLast) state_reg <= TXS_DATA;
               end
            end
            TXS_SKP_COM: begin
               state_reg      <= TXS_SKP_BODY;
               skp_idx_reg    <= '0;
               tx_sym_vec_reg <= {Width{SKP_SYM}};
               skp_active_reg <= 1'b1;
            end
            TXS_SKP_BODY: begin
               if (skp_idx_reg == IDX_LAST) begin
                  state_reg <= TXS_IDLE;
               end else begin
                  skp_idx_reg    <= skp_idx_reg + 3'd1;
                  tx_sym_vec_reg <= {Width{SKP_SYM}};
                  skp_active_reg <= 1'b1;
               end
            end
            TXS_OS: begin
               if (OsValid) begin
                  tx_sym_vec_reg <= os_bcast;
                  if (OsLast) state_reg <= TXS_IDLE;
               end
            end
            TXS_DATA: begin
               if (DataValid) begin
                  tx_sym_vec_reg <= DataVec;
                  if (DataLast) state_reg <= TXS_IDLE;
               end else begin
                  underrun_reg <= 1'b1;
               end
            end
            default: state_reg <= TXS_IDLE;
         endcase
      end
   end

   assign TxSymVec  = tx_sym_vec_reg;
   assign SkpActive = skp_active_reg;
   assign Underrun  = underrun_reg;

endmodule

// File: tb/tb_serialiser_tx_sched.sv
// Directed bench for serialiser_tx_sched: reset, SKP cadence, packet atomicity,
// priority, underrun, SkpEnable drop and reset mid-packet.
module tb_serialiser_tx_sched;

   localparam int W  = 4;
   localparam int VW = W * 9;
   localparam logic [8:0]    COM   = 9'h1BC;
   localparam logic [8:0]    SKP   = 9'h11C;
   localparam logic [8:0]    IDL   = 9'h000;
   localparam logic [VW-1:0] COM_V = {W{COM}};
   localparam logic [VW-1:0] SKP_V = {W{SKP}};
   localparam logic [VW-1:0] IDL_V = {W{IDL}};

   logic          Clk = 1'b0;
   logic          notReset, SkpEnable;
   logic          OsValid, OsLast, OsReady;
   logic [8:0]    OsSym;
   logic          DataValid, DataLast, DataReady;
   logic [VW-1:0] DataVec, TxSymVec;
   logic          SkpActive, Underrun;

   int n_tests = 0;
   int n_fail  = 0;
   int cyc     = 0;
   logic [VW-1:0] exp_tx;
   logic          exp_a, exp_b;

   always #5 Clk = ~Clk;

   serialiser_tx_sched #(
      .Width(W), .SkpInterval(16), .SkpLen(3)
   ) dut (
      .Clk      (Clk),
      .notReset (notReset),
      .SkpEnable(SkpEnable),
      .OsValid  (OsValid),
      .OsSym    (OsSym),
      .OsLast   (OsLast),
      .OsReady  (OsReady),
      .DataValid(DataValid),
      .DataVec  (DataVec),
      .DataLast (DataLast),
      .DataReady(DataReady),
      .TxSymVec (TxSymVec),
      .SkpActive(SkpActive),
      .Underrun (Underrun)
   );

   task automatic check(input string tag, input logic [VW-1:0] got, input logic [VW-1:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s cyc=%0d got=%h exp=%h", tag, cyc, got, exp);
      end
   endtask

   function automatic logic [VW-1:0] vec(input int j);
      logic [VW-1:0] r;
      for (int i = 0; i < W; i++) r[i*9 +: 9] = 9'(j * 16 + i + 1);
      return r;
   endfunction

   task automatic step();
      @(posedge Clk);
      @(negedge Clk);
      cyc++;
   endtask

   task automatic idle_inputs();
      OsValid = 1'b0; OsSym = '0; OsLast = 1'b0;
      DataValid = 1'b0; DataVec = '0; DataLast = 1'b0;
   endtask

   task automatic do_reset(input logic en);
      notReset = 1'b0; SkpEnable = en;
      idle_inputs();
      repeat (3) step();
      notReset = 1'b1;
      cyc = 0;
   endtask

   always @(posedge Clk) begin
      if (OsValid && OsReady) $display("[TB] cyc %0d os xfer sym=%h last=%0b", cyc, OsSym, OsLast);
      if (DataValid && DataReady) $display("[TB] cyc %0d data xfer last=%0b", cyc, DataLast);
   end

   initial begin
      // Reset with data offered: nothing accepted until release.
      notReset = 1'b0; SkpEnable = 1'b1;
      idle_inputs();
      DataValid = 1'b1; DataVec = vec(100); DataLast = 1'b1;
      repeat (3) step();
      check("rst_tx", TxSymVec, IDL_V);
      check("rst_drdy", DataReady, 1'b0);
      check("rst_act", SkpActive, 1'b0);
      check("rst_urun", Underrun, 1'b0);
      notReset = 1'b1; cyc = 0;
      #1 check("rel_drdy", DataReady, 1'b1);
      step();
      check("first_grant", TxSymVec, vec(100));
      DataValid = 1'b0;

      // Idle SKP cadence, then a packet straddling the next expiry.
      for (int c = 2; c <= 75; c++) begin
         step();
         exp_tx = IDL_V; exp_a = 1'b0;
         if (c == 16 || c == 32 || c == 56 || c == 72) begin
            exp_tx = COM_V; exp_a = 1'b1;
         end else if ((c >= 17 && c <= 19) || (c >= 33 && c <= 35) ||
                      (c >= 57 && c <= 59) || (c >= 73 && c <= 75)) begin
            exp_tx = SKP_V; exp_a = 1'b1;
         end else if (c >= 46 && c <= 55) begin
            exp_tx = vec(c - 46);
         end
         check("skp_tx", TxSymVec, exp_tx);
         check("skp_act", SkpActive, exp_a);
         if (c >= 45 && c <= 54) begin
            DataValid = 1'b1; DataVec = vec(c - 45); DataLast = (c == 54);
            #1 check("atom_drdy", DataReady, 1'b1);
         end else begin
            DataValid = 1'b0; DataLast = 1'b0;
         end
      end

      // OS beats data, then an underrun packet with an OS waiting behind it.
      do_reset(1'b0);
      for (int c = 0; c <= 27; c++) begin
         if (c > 0) step();
         exp_tx = IDL_V;
         if (c >= 1 && c <= 16) exp_tx = {W{9'(9'h0A0 + 9'(c - 1))}};
         else if (c == 17) exp_tx = vec(200);
         else if (c == 19) exp_tx = vec(300);
         else if (c == 20) exp_tx = vec(301);
         else if (c == 23) exp_tx = vec(302);
         else if (c == 24) exp_tx = vec(303);
         else if (c == 25) exp_tx = vec(304);
         else if (c == 26) exp_tx = {W{9'h155}};
         check("pri_tx", TxSymVec, exp_tx);
         check("pri_urun", Underrun, (c == 21 || c == 22));
         check("pri_act", SkpActive, 1'b0);
         idle_inputs();
         if (c <= 15) begin
            OsValid = 1'b1; OsSym = 9'(9'h0A0 + 9'(c)); OsLast = (c == 15);
         end else if (c >= 19 && c <= 25) begin
            OsValid = 1'b1; OsSym = 9'h155; OsLast = 1'b1;
         end
         if (c <= 16) begin
            DataValid = 1'b1; DataVec = vec(200); DataLast = 1'b1;
         end else if (c == 18 || c == 19) begin
            DataValid = 1'b1; DataVec = vec(300 + c - 18);
         end else if (c >= 22 && c <= 24) begin
            DataValid = 1'b1; DataVec = vec(302 + c - 22); DataLast = (c == 24);
         end
         exp_a = (c <= 15) || (c == 25);
         exp_b = (c == 16) || (c >= 18 && c <= 24);
         #1;
         check("pri_ordy", OsReady, exp_a);
         check("pri_drdy", DataReady, exp_b);
      end

      // SkpEnable dropped during the SKP body, then reset mid-packet.
      do_reset(1'b1);
      for (int c = 0; c <= 70; c++) begin
         if (c > 0) step();
         exp_tx = IDL_V; exp_a = 1'b0;
         if (c == 16 || c == 56) begin
            exp_tx = COM_V; exp_a = 1'b1;
         end else if ((c >= 17 && c <= 19) || (c >= 57 && c <= 59)) begin
            exp_tx = SKP_V; exp_a = 1'b1;
         end else if (c >= 62 && c <= 64) begin
            exp_tx = vec(400 + c - 62);
         end
         check("en_tx", TxSymVec, exp_tx);
         check("en_act", SkpActive, exp_a);
         SkpEnable = !(c >= 17 && c < 40);
         idle_inputs();
         notReset = (c != 64);
         if (c >= 61 && c <= 64) begin
            DataValid = 1'b1; DataVec = vec(400 + c - 61);
         end
         if (c >= 61 && c <= 65) begin
            #1 check("mid_drdy", DataReady, (c <= 63));
         end
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
